// File: rtl/pipeline_pkg.sv
// Shared types and constants for the five-stage pipeline stall controller.
package pipeline_pkg;

    // Controller states: normal issue, or waiting on the multicycle EX unit
    typedef enum logic {
        RUN     = 1'b0,
        MC_WAIT = 1'b1
    } ctrl_state_t;

    // Default register-address width (64-entry register file)
    localparam int REG_W_DEFAULT = 6;

    // Hard-wired zero register; never a real data dependency
    localparam logic [REG_W_DEFAULT-1:0] REG_ZERO = '0;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Clear wins over increment; increment stops at all-ones
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/pipeline_stall_controller.sv
// Stall/flush sequencer for the IF/ID/EX/ME/WB pipeline: load-use bubbles,
// multicycle EX operations and taken-branch flushes, plus a stall-cycle counter.
// Optional watchdog on multicycle operations: define PIPELINE_STALL_CONTROLLER_WDT_EN.
module pipeline_stall_controller
    import pipeline_pkg::*;
#(
    parameter int REG_W      = REG_W_DEFAULT,
    parameter int MC_TIMEOUT = 1024,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] ra_id,
    input  logic [REG_W-1:0] rb_id,
    input  logic [REG_W-1:0] rf_ex,
    input  logic             mem_read_ex,
    input  logic             mc_start_ex,
    input  logic             mc_done,
    input  logic             branch_taken_ex,
    output logic             stall_pc,
    output logic             stall_id,
    output logic             stall_ex,
    output logic             flush_id,
    output logic             flush_ex,
    output logic             mc_busy,
    output logic [CNT_W-1:0] stall_cycles,
    output logic             mc_timeout
);

    ctrl_state_t      state;
    ctrl_state_t      next_state;
    logic             load_use;
    logic             wdt_hit;
    logic             timeout_flag;
    logic             stall_pc_c;
    logic             stall_id_c;
    logic             stall_ex_c;
    logic             flush_id_c;
    logic             flush_ex_c;
    logic             mc_busy_c;
    logic [CNT_W-1:0] stall_count;

    // Register 0 is hard-wired, so a load targeting it never creates a hazard
    assign load_use = mem_read_ex
                   && (rf_ex != REG_W'(REG_ZERO))
                   && ((rf_ex == ra_id) || (rf_ex == rb_id));

    // Hazard priority and next-state selection
    always_comb begin
        next_state = state;
        stall_pc_c = 1'b0;
        stall_id_c = 1'b0;
        stall_ex_c = 1'b0;
        flush_id_c = 1'b0;
        flush_ex_c = 1'b0;
        mc_busy_c  = 1'b0;
        case (state)
            RUN: begin
                if (branch_taken_ex) begin
                    // Wrong-path instructions in IF/ID and ID/EX are squashed
                    flush_id_c = 1'b1;
                    flush_ex_c = 1'b1;
                end else if (mc_start_ex) begin
                    stall_pc_c = 1'b1;
                    stall_id_c = 1'b1;
                    stall_ex_c = 1'b1;
                    next_state = MC_WAIT;
                end else if (load_use) begin
                    // Hold fetch/decode and push one bubble into EX
                    stall_pc_c = 1'b1;
                    stall_id_c = 1'b1;
                    flush_ex_c = 1'b1;
                end
            end
            MC_WAIT: begin
                // Stalls drop in the mc_done cycle itself so the result is used at once
                mc_busy_c  = 1'b1;
                stall_pc_c = !mc_done;
                stall_id_c = !mc_done;
                stall_ex_c = !mc_done;
                if (mc_done || wdt_hit) begin
                    next_state = RUN;
                end
            end
            default: next_state = RUN;
        endcase
    end

    // Controller state register; reset aborts any multicycle wait
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= next_state;
        end
    end

    // Performance counter of cycles in which the PC is held
    sat_counter #(
        .W(CNT_W)
    ) u_stall_cnt (
        .clk  (clk),
        .rst  (rst),
        .clear(1'b0),
        .inc  (stall_pc_c),
        .count(stall_count)
    );

`ifdef PIPELINE_STALL_CONTROLLER_WDT_EN
    localparam int WDT_W = $clog2(MC_TIMEOUT + 1);

    logic [WDT_W-1:0] wdt_count;

    // Counts MC_WAIT cycles; held at zero in RUN so every operation starts fresh
    sat_counter #(
        .W(WDT_W)
    ) u_wdt_cnt (
        .clk  (clk),
        .rst  (rst),
        .clear(state == RUN),
        .inc  (state == MC_WAIT),
        .count(wdt_count)
    );

    // Last allowed wait cycle without a result; a simultaneous mc_done wins
    assign wdt_hit = (state == MC_WAIT) && !mc_done
                  && (wdt_count == WDT_W'(MC_TIMEOUT - 1));

    // Sticky error flag, cleared only by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            timeout_flag <= 1'b0;
        end else if (wdt_hit) begin
            timeout_flag <= 1'b1;
        end
    end
`else
    logic unused_cfg;

    assign unused_cfg   = ^MC_TIMEOUT;
    assign wdt_hit      = 1'b0;
    assign timeout_flag = 1'b0;
`endif

    // Everything is forced low while reset is held, independent of inputs
    assign stall_pc     = stall_pc_c && !rst;
    assign stall_id     = stall_id_c && !rst;
    assign stall_ex     = stall_ex_c && !rst;
    assign flush_id     = flush_id_c && !rst;
    assign flush_ex     = flush_ex_c && !rst;
    assign mc_busy      = mc_busy_c  && !rst;
    assign mc_timeout   = timeout_flag && !rst;
    assign stall_cycles = rst ? '0 : stall_count;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Scoreboard bench for pipeline_stall_controller: directed vectors push
// hand-computed expectations, a monitor compares each cycle's outputs.
module tb_pipeline_stall_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  ra_id = '0;
    logic [5:0]  rb_id = '0;
    logic [5:0]  rf_ex = '0;
    logic        mem_read_ex = 1'b0;
    logic        mc_start_ex = 1'b0;
    logic        mc_done = 1'b0;
    logic        branch_taken_ex = 1'b0;
    logic        stall_pc, stall_id, stall_ex, flush_id, flush_ex, mc_busy, mc_timeout;
    logic [15:0] stall_cycles;

    // {stall_pc, stall_id, stall_ex, flush_id, flush_ex, mc_busy, mc_timeout}
    localparam logic [6:0] IDLE = 7'b0000000;
    localparam logic [6:0] LDU  = 7'b1100100;
    localparam logic [6:0] BRF  = 7'b0001100;
    localparam logic [6:0] MCS  = 7'b1110000;
    localparam logic [6:0] MCW  = 7'b1110010;
    localparam logic [6:0] MCD  = 7'b0000010;
    localparam logic [6:0] TMO  = 7'b0000001;

    typedef struct {
        logic [6:0]  ctrl;
        logic [15:0] cnt;
        string       name;
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    pipeline_stall_controller #(
        .REG_W     (6),
        .MC_TIMEOUT(16),
        .CNT_W     (16)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .ra_id          (ra_id),
        .rb_id          (rb_id),
        .rf_ex          (rf_ex),
        .mem_read_ex    (mem_read_ex),
        .mc_start_ex    (mc_start_ex),
        .mc_done        (mc_done),
        .branch_taken_ex(branch_taken_ex),
        .stall_pc       (stall_pc),
        .stall_id       (stall_id),
        .stall_ex       (stall_ex),
        .flush_id       (flush_id),
        .flush_ex       (flush_ex),
        .mc_busy        (mc_busy),
        .stall_cycles   (stall_cycles),
        .mc_timeout     (mc_timeout)
    );

    // Apply one cycle of inputs just after the edge and record what must come out
    task automatic vec(input logic r, input logic [5:0] ra, input logic [5:0] rb,
                       input logic [5:0] rf, input logic mr, input logic mcs,
                       input logic mcd, input logic br, input logic [6:0] ec,
                       input logic [15:0] ecnt, input string name);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; ra_id = ra; rb_id = rb; rf_ex = rf;
        mem_read_ex = mr; mc_start_ex = mcs; mc_done = mcd; branch_taken_ex = br;
        e.ctrl = ec;
        e.cnt  = ecnt;
        e.name = name;
        q.push_back(e);
    endtask

    // Monitor: outputs are combinational, so every cycle presents a result mid-cycle
    initial begin
        exp_t e;
        logic [6:0] act;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                act = {stall_pc, stall_id, stall_ex, flush_id, flush_ex, mc_busy, mc_timeout};
                vectors++;
                if (act !== e.ctrl || stall_cycles !== e.cnt) begin
                    miscompares++;
                    $display("FAIL %s: got ctrl=%b cnt=%0d, want ctrl=%b cnt=%0d",
                             e.name, act, stall_cycles, e.ctrl, e.cnt);
                end
            end
        end
    end

    initial begin
        int guard;
        //   rst ra  rb  rf  mr mcs mcd br  expected
        vec(1, 5, 0, 5, 1, 1, 0, 0, IDLE, 16'd0, "reset_busy_inputs");
        vec(1, 0, 0, 0, 0, 0, 0, 0, IDLE, 16'd0, "reset_idle");
        vec(0, 0, 0, 0, 0, 0, 0, 0, IDLE, 16'd0, "run_idle");
        vec(0, 5, 0, 5, 1, 0, 0, 0, LDU,  16'd0, "load_use_ra");
        vec(0, 0, 0, 0, 0, 0, 0, 0, IDLE, 16'd1, "after_load_use");
        vec(0, 3, 7, 7, 1, 0, 0, 0, LDU,  16'd1, "load_use_rb");
        vec(0, 0, 0, 0, 1, 0, 0, 0, IDLE, 16'd2, "reg0_no_stall");
        vec(0, 5, 0, 5, 0, 0, 0, 0, IDLE, 16'd2, "match_not_load");
        vec(0, 0, 0, 0, 0, 0, 1, 0, IDLE, 16'd2, "spurious_done_run");
        vec(0, 5, 0, 5, 1, 1, 0, 1, BRF,  16'd2, "branch_priority");
        vec(0, 0, 0, 0, 0, 0, 0, 0, IDLE, 16'd2, "still_run");
        // Multicycle operation, mc_done 7 cycles after the start pulse
        vec(0, 0, 0, 0, 0, 1, 0, 0, MCS,  16'd2, "mc_start");
        vec(0, 0, 0, 0, 0, 0, 0, 0, MCW,  16'd3, "mc_wait1");
        vec(0, 5, 0, 5, 1, 1, 0, 1, MCW,  16'd4, "mc_wait_ignores");
        for (int i = 0; i < 4; i++)
            vec(0, 0, 0, 0, 0, 0, 0, 0, MCW, 16'(5 + i), "mc_wait");
        vec(0, 0, 0, 0, 0, 0, 1, 0, MCD,  16'd9, "mc_done_release");
        vec(0, 0, 0, 0, 0, 0, 0, 0, IDLE, 16'd9, "back_in_run");
        // Reset in the third wait cycle
        vec(0, 0, 0, 0, 0, 1, 0, 0, MCS,  16'd9,  "mc_start2");
        vec(0, 0, 0, 0, 0, 0, 0, 0, MCW,  16'd10, "mc2_wait1");
        vec(0, 0, 0, 0, 0, 0, 0, 0, MCW,  16'd11, "mc2_wait2");
        vec(1, 0, 0, 0, 0, 0, 0, 0, IDLE, 16'd0,  "reset_mid_wait");
        vec(0, 0, 0, 0, 0, 0, 0, 0, IDLE, 16'd0,  "run_after_reset");
        vec(0, 0, 0, 0, 0, 0, 1, 0, IDLE, 16'd0,  "done_after_reset");
        // Long operation: 16 wait cycles without a result
        vec(0, 0, 0, 0, 0, 1, 0, 0, MCS,  16'd0, "mc_start3");
        for (int i = 0; i < 16; i++)
            vec(0, 0, 0, 0, 0, 0, 0, 0, MCW, 16'(1 + i), "mc3_wait");
`ifdef PIPELINE_STALL_CONTROLLER_WDT_EN
        vec(0, 0, 0, 0, 0, 0, 0, 0, TMO,  16'd17, "wdt_timeout");
        vec(0, 5, 0, 5, 1, 0, 0, 0, 7'b1100101, 16'd17, "wdt_sticky_load_use");
        vec(0, 0, 0, 0, 0, 0, 0, 0, TMO,  16'd18, "wdt_sticky");
        vec(1, 0, 0, 0, 0, 0, 0, 0, IDLE, 16'd0,  "wdt_reset");
        vec(0, 0, 0, 0, 0, 0, 0, 0, IDLE, 16'd0,  "wdt_cleared");
`else
        for (int i = 0; i < 3; i++)
            vec(0, 0, 0, 0, 0, 0, 0, 0, MCW, 16'(17 + i), "mc3_wait_long");
        vec(0, 0, 0, 0, 0, 0, 1, 0, MCD,  16'd20, "mc3_done");
        vec(0, 0, 0, 0, 0, 0, 0, 0, IDLE, 16'd20, "mc3_run");
        vec(0, 0, 0, 0, 0, 0, 0, 0, TMO & 7'b0, 16'd20, "no_timeout_flag");
`endif
        guard = 0;
        while (q.size() > 0 && guard < 10) begin
            @(posedge clk);
            guard++;
        end
        if (q.size() > 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
